nn_sld_feeder: RTL and testbench

- Reads image columns from the activation buffer's 1-cycle-latency read port.
- Drives the sliding-window register file: 6-byte column data, a shift strobe, and mode/half-select.
- Preloads a full window, then advances it one column per handshake with the PE array until every window position in the image row-strip is consumed.
- Sits between the activation buffer and the sliding register file, under control of the layer sequencer.

---
 rtl/nn_sld_feeder.sv | 119 +++++++++++
 tb/tb_nn_sld_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sld_feeder.sv
// Feeds image columns from the activation buffer into the sliding-window register file,
// preloading one window and then stepping it a column at a time under PE-array handshake.
module nn_sld_feeder #(
   parameter int DATA_WIDTH     = 8,
   parameter int ROW_NUM        = 6,
   parameter int COL_DATA_WIDTH = DATA_WIDTH * ROW_NUM,
   parameter int ADDR_WIDTH     = 10,
   parameter int COL_CNT_WIDTH  = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [ADDR_WIDTH-1:0]     i_base_addr,
   input  logic [COL_CNT_WIDTH-1:0]  i_img_cols,
   input  logic [1:0]                i_mode,
   input  logic                      i_3x3,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_rd_en,
   output logic [ADDR_WIDTH-1:0]     o_rd_addr,
   input  logic [COL_DATA_WIDTH-1:0] i_rd_data,
   output logic [COL_DATA_WIDTH-1:0] o_data,
   output logic                      o_shift,
   output logic [1:0]                o_mode,
   output logic                      o_3x3,
   output logic                      o_win_valid,
   input  logic                      i_win_ready
);

   typedef enum logic [2:0] {IDLE, FILL, DRAIN, VALID, STEP, DONE} state_t;

   state_t                     state, state_nxt;
   logic [ADDR_WIDTH-1:0]      base_q;
   logic [COL_CNT_WIDTH-1:0]   cols_q;
   logic [COL_CNT_WIDTH-1:0]   win_cnt;
   logic [2:0]                 fill_cnt;
   logic                       k6_q;
   logic                       rd_pend;
   logic [ADDR_WIDTH-1:0]      rd_off;
   logic [COL_CNT_WIDTH-1:0]   k_val;
   logic [COL_CNT_WIDTH-1:0]   start_k;
   logic                       accept;

   assign k_val   = k6_q ? COL_CNT_WIDTH'(6) : COL_CNT_WIDTH'(3);
   assign start_k = (i_mode == 2'b00) ? COL_CNT_WIDTH'(3) : COL_CNT_WIDTH'(6);
   assign accept  = (state == IDLE) && i_start;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // The window is only declared valid once the read issued last has landed as a shift.
   always_comb begin
      state_nxt = state;
      o_rd_en   = 1'b0;
      rd_off    = '0;
      case (state)
         IDLE:  if (i_start) state_nxt = (i_img_cols < start_k) ? DONE : FILL;
         FILL: begin
            o_rd_en = 1'b1;
            rd_off  = ADDR_WIDTH'(fill_cnt);
            if (COL_CNT_WIDTH'(fill_cnt) == k_val - COL_CNT_WIDTH'(1)) state_nxt = DRAIN;
         end
         DRAIN: if (o_shift && !rd_pend) state_nxt = VALID;
         VALID: if (i_win_ready) state_nxt = (win_cnt == cols_q - k_val) ? DONE : STEP;
         STEP: begin
            o_rd_en   = 1'b1;
            rd_off    = ADDR_WIDTH'(k_val) + ADDR_WIDTH'(win_cnt);
            state_nxt = DRAIN;
         end
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_rd_addr   = o_rd_en ? (base_q + rd_off) : '0;
   assign o_busy      = (state != IDLE);
   assign o_done      = (state == DONE);
   assign o_win_valid = (state == VALID);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         base_q   <= '0;
         cols_q   <= '0;
         o_mode   <= 2'b00;
         o_3x3    <= 1'b0;
         k6_q     <= 1'b0;
         fill_cnt <= '0;
         win_cnt  <= '0;
      end else begin
         if (accept) begin
            base_q   <= i_base_addr;
            cols_q   <= i_img_cols;
            o_mode   <= i_mode;
            o_3x3    <= i_3x3;
            k6_q     <= (i_mode != 2'b00);
            fill_cnt <= '0;
            win_cnt  <= '0;
         end
         if (state == FILL) fill_cnt <= fill_cnt + 3'd1;
         if (state == STEP) win_cnt  <= win_cnt + COL_CNT_WIDTH'(1);
      end
   end

   // Buffer data arrives one cycle after the read and is registered out as a shift the next.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_pend <= 1'b0;
         o_shift <= 1'b0;
         o_data  <= '0;
      end else begin
         rd_pend <= o_rd_en;
         o_shift <= rd_pend;
         if (rd_pend) o_data <= i_rd_data;
      end
   end

endmodule

// File: tb/tb_nn_sld_feeder.sv
// Self-checking bench for nn_sld_feeder: strips are run against a model that derives reads,
// shifted columns and window contents directly from column counts and window width.
module tb_nn_sld_feeder;

   logic        i_clk, i_rst, i_start, i_3x3, i_win_ready;
   logic [9:0]  i_base_addr;
   logic [7:0]  i_img_cols;
   logic [1:0]  i_mode;
   logic [47:0] i_rd_data;
   logic        o_busy, o_done, o_rd_en, o_shift, o_3x3, o_win_valid;
   logic [9:0]  o_rd_addr;
   logic [47:0] o_data;
   logic [1:0]  o_mode;

   int n_checks, n_fail;
   logic [31:0] salt;

   logic [9:0]  obs_addr[$];
   logic [47:0] obs_shift[$];
   logic [47:0] obs_win[$];
   int obs_first_rd, obs_done_cnt, obs_done_cyc, obs_last_hs, obs_hs_cnt;
   int obs_lat_bad, obs_viol, obs_mode_bad, obs_valid_cyc, obs_post_busy, obs_timeout;

   nn_sld_feeder dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_img_cols(i_img_cols), .i_mode(i_mode), .i_3x3(i_3x3), .o_busy(o_busy),
      .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
      .o_data(o_data), .o_shift(o_shift), .o_mode(o_mode), .o_3x3(o_3x3),
      .o_win_valid(o_win_valid), .i_win_ready(i_win_ready)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic logic [47:0] tag(input logic [9:0] a);
      return {salt, 6'd0, a};
   endfunction

   // Activation buffer: one-cycle read latency, every column tagged with its address.
   always @(posedge i_clk) if (o_rd_en) i_rd_data <= tag(o_rd_addr);

   // Drives one strip and records what the DUT did, cycle by cycle, relative to the start edge.
   task automatic run_strip(input logic [9:0] base, input logic [7:0] cols, input logic [1:0] mode,
                            input logic x3, input int hold, input int pct, input bit spam);
      int cyc, h;
      bit done, prev_valid, rdy;
      obs_addr.delete(); obs_shift.delete(); obs_win.delete();
      obs_first_rd = -1; obs_done_cnt = 0; obs_done_cyc = -1; obs_last_hs = -1; obs_hs_cnt = 0;
      obs_lat_bad = 0; obs_viol = 0; obs_mode_bad = 0; obs_valid_cyc = 0; obs_timeout = 0;
      salt = $urandom;
      h = hold;
      @(negedge i_clk);
      i_base_addr = base; i_img_cols = cols; i_mode = mode; i_3x3 = x3;
      i_start = 1'b1; i_win_ready = 1'b0;
      @(negedge i_clk);
      cyc = 1;
      if (spam) begin
         i_mode = ~mode; i_3x3 = ~x3; i_base_addr = base ^ 10'h155; i_img_cols = cols ^ 8'h0F;
      end else i_start = 1'b0;
      done = 1'b0; prev_valid = 1'b0;
      while (!done && cyc < 3000) begin
         if (o_rd_en) begin
            obs_addr.push_back(o_rd_addr);
            if (obs_first_rd < 0) obs_first_rd = cyc;
         end
         if (o_shift) obs_shift.push_back(o_data);
         if (o_win_valid && (o_rd_en || o_shift)) obs_viol++;
         if (o_mode !== mode || o_3x3 !== x3) obs_mode_bad++;
         if (o_win_valid && !prev_valid && obs_last_hs >= 0 && cyc - obs_last_hs != 4) obs_lat_bad++;
         if (o_win_valid) begin
            obs_valid_cyc++;
            if (h > 0) begin rdy = 1'b0; h--; end
            else rdy = ($urandom_range(99) < pct);
            if (rdy) begin
               obs_win.push_back(o_data);
               obs_last_hs = cyc;
               obs_hs_cnt++;
            end
         end else rdy = 1'($urandom_range(1));
         i_win_ready = rdy;
         if (o_done) begin
            obs_done_cnt++; obs_done_cyc = cyc; done = 1'b1; i_start = 1'b0;
         end
         prev_valid = o_win_valid;
         @(negedge i_clk);
         cyc++;
      end
      if (!done) obs_timeout = 1;
      obs_post_busy = int'(o_busy);
      i_win_ready = 1'b0; i_start = 1'b0;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      n_checks++;
      if ({o_busy, o_done, o_rd_en, o_rd_addr, o_data, o_shift, o_mode, o_3x3, o_win_valid} !== '0) begin
         n_fail++; $display("[TB] FAIL reset_outputs: outputs not all zero during reset");
      end
      i_rst = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if ({o_busy, o_rd_en, o_win_valid, o_done} !== 4'b0) begin
         n_fail++; $display("[TB] FAIL reset_idle: busy/rd/valid/done=%b required 0000",
                            {o_busy, o_rd_en, o_win_valid, o_done});
      end
   endtask

   // Runs one strip scenario and compares the recorded behaviour with the model.
   task automatic test_strip(input string nm, input logic [9:0] base, input logic [7:0] cols,
                             input logic [1:0] mode, input logic x3, input int hold, input int pct,
                             input bit spam);
      int k, nwin, nrd;
      logic [9:0] a;
      run_strip(base, cols, mode, x3, hold, pct, spam);
      k    = (mode == 2'b00) ? 3 : 6;
      nwin = (int'(cols) >= k) ? int'(cols) - k + 1 : 0;
      nrd  = (nwin > 0) ? int'(cols) : 0;
      n_checks++;
      if (obs_timeout != 0) begin n_fail++; $display("[TB] FAIL %s timeout: no o_done seen", nm); end
      n_checks++;
      if (obs_done_cnt != 1) begin n_fail++; $display("[TB] FAIL %s done_count: got %0d want 1", nm, obs_done_cnt); end
      n_checks++;
      if (obs_hs_cnt != nwin) begin n_fail++; $display("[TB] FAIL %s windows: got %0d want %0d", nm, obs_hs_cnt, nwin); end
      n_checks++;
      if (obs_addr.size() != nrd) begin n_fail++; $display("[TB] FAIL %s reads: got %0d want %0d", nm, obs_addr.size(), nrd); end
      n_checks++;
      if (obs_shift.size() != nrd) begin n_fail++; $display("[TB] FAIL %s shifts: got %0d want %0d", nm, obs_shift.size(), nrd); end
      for (int i = 0; i < obs_addr.size() && i < nrd; i++) begin
         a = base + 10'(i);
         n_checks++;
         if (obs_addr[i] !== a) begin n_fail++; $display("[TB] FAIL %s rd_addr[%0d]: got %h want %h", nm, i, obs_addr[i], a); end
      end
      for (int i = 0; i < obs_shift.size() && i < nrd; i++) begin
         n_checks++;
         if (obs_shift[i] !== tag(base + 10'(i))) begin
            n_fail++; $display("[TB] FAIL %s shift_data[%0d]: got %h want %h", nm, i, obs_shift[i], tag(base + 10'(i)));
         end
      end
      for (int w = 0; w < obs_win.size() && w < nwin; w++) begin
         n_checks++;
         if (obs_win[w] !== tag(base + 10'(w + k - 1))) begin
            n_fail++; $display("[TB] FAIL %s window_col[%0d]: got %h want %h", nm, w, obs_win[w], tag(base + 10'(w + k - 1)));
         end
      end
      if (nwin > 0) begin
         n_checks++;
         if (obs_done_cyc != obs_last_hs + 1) begin
            n_fail++; $display("[TB] FAIL %s done_timing: done at %0d want %0d", nm, obs_done_cyc, obs_last_hs + 1);
         end
         n_checks++;
         if (obs_first_rd != 1) begin n_fail++; $display("[TB] FAIL %s first_read: cycle %0d want 1", nm, obs_first_rd); end
      end else begin
         n_checks++;
         if (obs_valid_cyc != 0 || obs_done_cyc < 1 || obs_done_cyc > 2) begin
            n_fail++; $display("[TB] FAIL %s short_strip: valid_cycles %0d done_cycle %0d want 0 and 1..2", nm, obs_valid_cyc, obs_done_cyc);
         end
      end
      n_checks++;
      if (obs_lat_bad != 0) begin n_fail++; $display("[TB] FAIL %s step_latency: %0d windows not 4 cycles after handshake", nm, obs_lat_bad); end
      n_checks++;
      if (obs_viol != 0) begin n_fail++; $display("[TB] FAIL %s activity_while_valid: %0d cycles want 0", nm, obs_viol); end
      n_checks++;
      if (obs_mode_bad != 0) begin n_fail++; $display("[TB] FAIL %s mode_latch: %0d bad cycles want 0", nm, obs_mode_bad); end
      n_checks++;
      if (obs_post_busy != 0) begin n_fail++; $display("[TB] FAIL %s busy_after_done: got %0d want 0", nm, obs_post_busy); end
   endtask

   task automatic test_stall;
      test_strip("stall", 10'h040, 8'd6, 2'b10, 1'b0, 20, 100, 1'b0);
      n_checks++;
      if (obs_valid_cyc != 21) begin n_fail++; $display("[TB] FAIL stall_valid_cycles: got %0d want 21", obs_valid_cyc); end
   endtask

   task automatic test_reset_abort;
      int cnt, bad;
      salt = $urandom;
      @(negedge i_clk);
      i_base_addr = 10'h020; i_img_cols = 8'd8; i_mode = 2'b01; i_3x3 = 1'b0; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      cnt = 0;
      while (!o_win_valid && cnt < 50) begin @(negedge i_clk); cnt++; end
      n_checks++;
      if (!o_win_valid) begin n_fail++; $display("[TB] FAIL abort_first_window: valid=%b want 1", o_win_valid); end
      i_win_ready = 1'b1;
      @(negedge i_clk);
      i_win_ready = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      n_checks++;
      if ({o_busy, o_done, o_rd_en, o_rd_addr, o_data, o_shift, o_mode, o_3x3, o_win_valid} !== '0) begin
         n_fail++; $display("[TB] FAIL abort_outputs: data=%h busy=%b mode=%b want all zero", o_data, o_busy, o_mode);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge i_clk);
         if (o_done || o_rd_en || o_shift || o_busy) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("[TB] FAIL abort_quiet: %0d active cycles want 0", bad); end
      test_strip("after_abort", 10'h100, 8'd9, 2'b01, 1'b1, 0, 100, 1'b0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 10; n++)
         test_strip("random", 10'($urandom), 8'($urandom_range(20)), 2'($urandom), 1'($urandom),
                    $urandom_range(3), $urandom_range(30, 100), 1'($urandom));
   endtask

   initial begin
      n_checks = 0; n_fail = 0; salt = '0;
      i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_img_cols = '0; i_mode = '0;
      i_3x3 = 1'b0; i_win_ready = 1'b0; i_rd_data = '0;
      test_reset;
      test_strip("mode01_basic", 10'h010, 8'd8, 2'b01, 1'b0, 0, 100, 1'b0);
      test_strip("mode00_3x3", 10'h0A0, 8'd5, 2'b00, 1'b1, 0, 100, 1'b0);
      test_stall;
      test_strip("short_strip", 10'h030, 8'd4, 2'b01, 1'b0, 0, 100, 1'b0);
      test_strip("addr_wrap", 10'h3FE, 8'd7, 2'b11, 1'b0, 0, 100, 1'b0);
      test_strip("start_while_busy", 10'h050, 8'd7, 2'b00, 1'b0, 0, 100, 1'b1);
      test_reset_abort;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
